// File: rtl/card_pkg.sv
// Shared sizes, state encoding and index helper for the card-array controller.
package card_pkg;

  localparam int DEF_N_CARDS   = 16;
  localparam int DEF_SYM_W     = 4;
  localparam int DEF_FAIL_HOLD = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ONE   = 2'd1,
    ST_CHECK = 2'd2,
    ST_HOLD  = 2'd3
  } card_state_e;

  function automatic logic idx_oob(input int unsigned idx, input int unsigned n);
    return idx >= n;
  endfunction

endpackage

// File: rtl/card_sym_store.sv
// Per-card symbol register file: one synchronous write port, two combinational reads.
module card_sym_store
  import card_pkg::*;
#(
  parameter int N_CARDS = DEF_N_CARDS,
  parameter int SYM_W   = DEF_SYM_W,
  parameter int IDX_W   = $clog2(N_CARDS)
) (
  input  logic             clk,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_addr_i,
  input  logic [SYM_W-1:0] wr_sym_i,
  input  logic [IDX_W-1:0] rd_a_idx_i,
  output logic [SYM_W-1:0] rd_a_sym_o,
  input  logic [IDX_W-1:0] rd_b_idx_i,
  output logic [SYM_W-1:0] rd_b_sym_o
);

  logic [SYM_W-1:0] mem_q [N_CARDS];

  // Symbols are board content, not control state, so they carry no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_sym_i;
  end

  assign rd_a_sym_o = mem_q[rd_a_idx_i];
  assign rd_b_sym_o = mem_q[rd_b_idx_i];

endmodule

// File: rtl/card_array_ctrl.sv
// Board-level controller: selection, pair compare, external path check, hide and game-over.
module card_array_ctrl
  import card_pkg::*;
#(
  parameter int N_CARDS   = DEF_N_CARDS,
  parameter int SYM_W     = DEF_SYM_W,
  parameter int IDX_W     = $clog2(N_CARDS),
  parameter int FAIL_HOLD = DEF_FAIL_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [SYM_W-1:0]   wr_sym,
  input  logic [IDX_W-1:0]   cur_idx,
  input  logic               s,
  input  logic               chk_ack,
  input  logic               chk_ok,
  output logic               chk_req,
  output logic [IDX_W-1:0]   chk_a,
  output logic [IDX_W-1:0]   chk_b,
  output logic [N_CARDS-1:0] sel,
  output logic [N_CARDS-1:0] blink,
  output logic [N_CARDS-1:0] hidden,
  output logic               ms,
  output logic               mf,
  output logic [IDX_W-1:0]   pairs_left,
  output logic               done
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ONE   = ST_ONE;
  localparam logic [1:0] CHECK = ST_CHECK;
  localparam logic [1:0] HOLD  = ST_HOLD;

  localparam int               CNT_W      = $clog2(FAIL_HOLD + 1);
  localparam logic [IDX_W-1:0] PAIRS_INIT = IDX_W'(N_CARDS / 2);

  logic [1:0]         state_q, state_d;
  logic [IDX_W-1:0]   idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [SYM_W-1:0]   sym_a_q, sym_a_d;
  logic               clob_q, clob_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [N_CARDS-1:0] sel_q, sel_d, hidden_q, hidden_d, blink_q, blink_d;
  logic [IDX_W-1:0]   pairs_q, pairs_d;
  logic               ms_q, ms_d, mf_q, mf_d, req_q, req_d, done_q, done_d;

  logic               pick_ok, wr_ok;
  logic [SYM_W-1:0]   rd_a_sym, rd_cur_sym, sym_a_eff;

  assign pick_ok = s && !idx_oob(32'(cur_idx), N_CARDS) && !hidden_q[cur_idx];
  assign wr_ok   = wr_en && (state_q == IDLE) && (sel_q == '0)
                   && !idx_oob(32'(wr_addr), N_CARDS);

  card_sym_store #(
    .N_CARDS (N_CARDS),
    .SYM_W   (SYM_W),
    .IDX_W   (IDX_W)
  ) u_store (
    .clk        (clk),
    .wr_en_i    (wr_ok),
    .wr_addr_i  (wr_addr),
    .wr_sym_i   (wr_sym),
    .rd_a_idx_i (idx_a_q),
    .rd_a_sym_o (rd_a_sym),
    .rd_b_idx_i (cur_idx),
    .rd_b_sym_o (rd_cur_sym)
  );

  // A write landing on the first card in its own pick cycle must not affect the
  // compare, so that one case uses the symbol captured before the write.
  assign sym_a_eff = clob_q ? sym_a_q : rd_a_sym;

  always_comb begin
    state_d  = state_q;
    idx_a_d  = idx_a_q;
    idx_b_d  = idx_b_q;
    sym_a_d  = sym_a_q;
    clob_d   = clob_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    hidden_d = hidden_q;
    pairs_d  = pairs_q;
    ms_d     = 1'b0;
    mf_d     = 1'b0;
    req_d    = req_q;

    if (new_game) begin
      state_d  = IDLE;
      sel_d    = '0;
      hidden_d = '0;
      pairs_d  = PAIRS_INIT;
      req_d    = 1'b0;
      cnt_d    = '0;
      clob_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_ok) begin
            idx_a_d         = cur_idx;
            sym_a_d         = rd_cur_sym;
            clob_d          = wr_ok && (wr_addr == cur_idx);
            sel_d[cur_idx]  = 1'b1;
            state_d         = ONE;
          end
        end
        ONE: begin
          if (pick_ok) begin
            if (cur_idx == idx_a_q) begin
              sel_d[idx_a_q] = 1'b0;
              state_d        = IDLE;
            end else begin
              idx_b_d        = cur_idx;
              sel_d[cur_idx] = 1'b1;
              if (sym_a_eff == rd_cur_sym) begin
                req_d   = 1'b1;
                state_d = CHECK;
              end else begin
                mf_d    = 1'b1;
                cnt_d   = CNT_W'(FAIL_HOLD);
                state_d = HOLD;
              end
            end
          end
        end
        CHECK: begin
          if (chk_ack) begin
            req_d = 1'b0;
            if (chk_ok) begin
              sel_d[idx_a_q]    = 1'b0;
              sel_d[idx_b_q]    = 1'b0;
              hidden_d[idx_a_q] = 1'b1;
              hidden_d[idx_b_q] = 1'b1;
              if (pairs_q != '0) pairs_d = pairs_q - IDX_W'(1);
              ms_d    = 1'b1;
              state_d = IDLE;
            end else begin
              mf_d    = 1'b1;
              cnt_d   = CNT_W'(FAIL_HOLD);
              state_d = HOLD;
            end
          end
        end
        default: begin
          if (cnt_q <= CNT_W'(1)) begin
            sel_d[idx_a_q] = 1'b0;
            sel_d[idx_b_q] = 1'b0;
            cnt_d          = '0;
            state_d        = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    blink_d = '0;
    for (int i = 0; i < N_CARDS; i++) begin
      blink_d[i] = (cur_idx == IDX_W'(i)) && !hidden_q[i];
    end
  end

  // done follows pairs_left by one cycle; a new game drops it at once.
  assign done_d = !new_game && (pairs_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_a_q  <= '0;
      idx_b_q  <= '0;
      sym_a_q  <= '0;
      clob_q   <= 1'b0;
      cnt_q    <= '0;
      sel_q    <= '0;
      hidden_q <= '0;
      blink_q  <= '0;
      pairs_q  <= PAIRS_INIT;
      ms_q     <= 1'b0;
      mf_q     <= 1'b0;
      req_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_a_q  <= idx_a_d;
      idx_b_q  <= idx_b_d;
      sym_a_q  <= sym_a_d;
      clob_q   <= clob_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      hidden_q <= hidden_d;
      blink_q  <= blink_d;
      pairs_q  <= pairs_d;
      ms_q     <= ms_d;
      mf_q     <= mf_d;
      req_q    <= req_d;
      done_q   <= done_d;
    end
  end

  assign chk_req    = req_q;
  assign chk_a      = idx_a_q;
  assign chk_b      = idx_b_q;
  assign sel        = sel_q;
  assign blink      = blink_q;
  assign hidden     = hidden_q;
  assign ms         = ms_q;
  assign mf         = mf_q;
  assign pairs_left = pairs_q;
  assign done       = done_q;

endmodule

// File: tb/tb_card_array_ctrl.sv
// Directed bench for card_array_ctrl with N_CARDS=16, SYM_W=4, FAIL_HOLD=8.
module tb_card_array_ctrl;

  logic        clk, rst, new_game, wr_en, s, chk_ack, chk_ok;
  logic [3:0]  wr_addr, wr_sym, cur_idx;
  logic        chk_req, ms, mf, done;
  logic [3:0]  chk_a, chk_b, pairs_left;
  logic [15:0] sel, blink, hidden;

  int checks = 0;
  int errors = 0;

  card_array_ctrl #(.N_CARDS(16), .SYM_W(4), .FAIL_HOLD(8)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_sym(wr_sym), .cur_idx(cur_idx), .s(s), .chk_ack(chk_ack), .chk_ok(chk_ok),
    .chk_req(chk_req), .chk_a(chk_a), .chk_b(chk_b), .sel(sel), .blink(blink),
    .hidden(hidden), .ms(ms), .mf(mf), .pairs_left(pairs_left), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_sym(input logic [3:0] a, input logic [3:0] v);
    wr_en = 1'b1; wr_addr = a; wr_sym = v;
    step();
    wr_en = 1'b0;
  endtask

  task automatic pick(input logic [3:0] i);
    cur_idx = i; s = 1'b1;
    step();
    s = 1'b0;
  endtask

  task automatic pulse_new_game();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
  endtask

  task automatic ack(input logic ok);
    chk_ack = 1'b1; chk_ok = ok;
    step();
    chk_ack = 1'b0; chk_ok = 1'b0;
  endtask

  // Counts cycles (including the current one) that sel equals pattern, bounded.
  task automatic hold_len(input logic [15:0] pattern, output int n, output int mf_seen);
    n = (sel == pattern) ? 1 : 0;
    mf_seen = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      if (mf) mf_seen++;
      if (sel == pattern) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; new_game = 0; wr_en = 0; wr_addr = 0; wr_sym = 0;
    cur_idx = 0; s = 0; chk_ack = 0; chk_ok = 0;
    repeat (3) step();
    rst = 1'b0;
    checks++; if (sel !== 16'h0) begin errors++; $display("FAIL reset_sel got %h exp 0000", sel); end
    checks++; if (hidden !== 16'h0) begin errors++; $display("FAIL reset_hidden got %h exp 0000", hidden); end
    checks++; if (pairs_left !== 4'd8) begin errors++; $display("FAIL reset_pairs got %0d exp 8", pairs_left); end
    checks++; if ({done, chk_req, ms, mf} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {done, chk_req, ms, mf}); end
    checks++; if (blink !== 16'h0) begin errors++; $display("FAIL reset_blink got %h exp 0000", blink); end
    pulse_new_game();
    checks++; if (pairs_left !== 4'd8 || sel !== 16'h0 || chk_req !== 1'b0) begin errors++; $display("FAIL newgame_state got pairs=%0d sel=%h req=%b exp 8 0000 0", pairs_left, sel, chk_req); end
    checks++; if (blink !== 16'h0001) begin errors++; $display("FAIL blink_cursor0 got %h exp 0001", blink); end
  endtask

  task automatic test_match();
    write_sym(4'd3, 4'd5);
    write_sym(4'd9, 4'd5);
    pick(4'd3);
    checks++; if (sel !== 16'h0008) begin errors++; $display("FAIL match_first_sel got %h exp 0008", sel); end
    pick(4'd9);
    checks++; if (chk_req !== 1'b1 || chk_a !== 4'd3 || chk_b !== 4'd9) begin errors++; $display("FAIL match_req got req=%b a=%0d b=%0d exp 1 3 9", chk_req, chk_a, chk_b); end
    checks++; if (sel !== 16'h0208) begin errors++; $display("FAIL match_both_sel got %h exp 0208", sel); end
    step();
    checks++; if (chk_req !== 1'b1 || chk_a !== 4'd3 || chk_b !== 4'd9 || ms !== 1'b0) begin errors++; $display("FAIL match_req_stable got req=%b a=%0d b=%0d ms=%b exp 1 3 9 0", chk_req, chk_a, chk_b, ms); end
    ack(1'b1);
    checks++; if (ms !== 1'b1 || mf !== 1'b0) begin errors++; $display("FAIL match_ms got ms=%b mf=%b exp 1 0", ms, mf); end
    checks++; if (hidden !== 16'h0208 || sel !== 16'h0 || pairs_left !== 4'd7 || chk_req !== 1'b0) begin errors++; $display("FAIL match_result got hid=%h sel=%h pairs=%0d req=%b exp 0208 0000 7 0", hidden, sel, pairs_left, chk_req); end
    step();
    checks++; if (ms !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL match_ms_pulse got ms=%b done=%b exp 0 0", ms, done); end
    checks++; if (blink !== 16'h0) begin errors++; $display("FAIL blink_hidden got %h exp 0000", blink); end
  endtask

  task automatic test_mismatch();
    int n, mfs;
    write_sym(4'd1, 4'd2);
    write_sym(4'd2, 4'd7);
    pick(4'd1);
    pick(4'd2);
    checks++; if (mf !== 1'b1 || chk_req !== 1'b0 || sel !== 16'h0006) begin errors++; $display("FAIL mismatch_mf got mf=%b req=%b sel=%h exp 1 0 0006", mf, chk_req, sel); end
    hold_len(16'h0006, n, mfs);
    checks++; if (n !== 8) begin errors++; $display("FAIL mismatch_hold got %0d exp 8 cycles", n); end
    checks++; if (mfs !== 0 || sel !== 16'h0) begin errors++; $display("FAIL mismatch_clear got mf_extra=%0d sel=%h exp 0 0000", mfs, sel); end
  endtask

  task automatic test_deselect_and_ignore();
    int n, mfs;
    pick(4'd4);
    checks++; if (sel !== 16'h0010) begin errors++; $display("FAIL deselect_set got %h exp 0010", sel); end
    pick(4'd4);
    checks++; if (sel !== 16'h0) begin errors++; $display("FAIL deselect_clear got %h exp 0000", sel); end
    pick(4'd3);
    checks++; if (sel !== 16'h0) begin errors++; $display("FAIL pick_hidden got %h exp 0000", sel); end
    write_sym(4'd5, 4'd1);
    write_sym(4'd6, 4'd2);
    pick(4'd5);
    pick(4'd6);
    pick(4'd7);
    pick(4'd0);
    checks++; if (sel !== 16'h0060) begin errors++; $display("FAIL pick_in_hold got %h exp 0060", sel); end
    hold_len(16'h0060, n, mfs);
    checks++; if (n !== 6 || sel !== 16'h0) begin errors++; $display("FAIL hold_after_picks got %0d sel=%h exp 6 0000", n, sel); end
  endtask

  task automatic test_checker_reject();
    int n, mfs;
    write_sym(4'd10, 4'd9);
    write_sym(4'd11, 4'd9);
    pick(4'd10);
    pick(4'd11);
    ack(1'b0);
    checks++; if (mf !== 1'b1 || ms !== 1'b0 || chk_req !== 1'b0) begin errors++; $display("FAIL reject_mf got mf=%b ms=%b req=%b exp 1 0 0", mf, ms, chk_req); end
    checks++; if (hidden !== 16'h0208 || pairs_left !== 4'd7) begin errors++; $display("FAIL reject_hidden got %h pairs=%0d exp 0208 7", hidden, pairs_left); end
    hold_len(16'h0C00, n, mfs);
    checks++; if (n !== 8 || sel !== 16'h0) begin errors++; $display("FAIL reject_hold got %0d sel=%h exp 8 0000", n, sel); end
  endtask

  task automatic test_full_game();
    pulse_new_game();
    for (int i = 0; i < 16; i++) write_sym(4'(i), 4'(i / 2));
    for (int k = 0; k < 8; k++) begin
      pick(4'(2 * k));
      pick(4'(2 * k + 1));
      checks++; if (chk_req !== 1'b1 || chk_a !== 4'(2 * k) || chk_b !== 4'(2 * k + 1)) begin errors++; $display("FAIL game_req%0d got req=%b a=%0d b=%0d", k, chk_req, chk_a, chk_b); end
      ack(1'b1);
      checks++; if (ms !== 1'b1 || pairs_left !== 4'(7 - k) || done !== 1'b0) begin errors++; $display("FAIL game_ms%0d got ms=%b pairs=%0d done=%b exp 1 %0d 0", k, ms, pairs_left, done, 7 - k); end
    end
    step();
    checks++; if (done !== 1'b1 || hidden !== 16'hFFFF || ms !== 1'b0) begin errors++; $display("FAIL game_done got done=%b hid=%h ms=%b exp 1 ffff 0", done, hidden, ms); end
    checks++; if (blink !== 16'h0) begin errors++; $display("FAIL game_blink got %h exp 0000", blink); end
  endtask

  task automatic test_new_game_in_check();
    pulse_new_game();
    checks++; if (pairs_left !== 4'd8 || done !== 1'b0 || hidden !== 16'h0) begin errors++; $display("FAIL ng_reload got pairs=%0d done=%b hid=%h exp 8 0 0000", pairs_left, done, hidden); end
    pick(4'd0);
    pick(4'd1);
    checks++; if (chk_req !== 1'b1) begin errors++; $display("FAIL ng_req_up got %b exp 1", chk_req); end
    pulse_new_game();
    checks++; if (chk_req !== 1'b0 || sel !== 16'h0) begin errors++; $display("FAIL ng_drop got req=%b sel=%h exp 0 0000", chk_req, sel); end
    ack(1'b1);
    checks++; if (ms !== 1'b0 || hidden !== 16'h0 || pairs_left !== 4'd8) begin errors++; $display("FAIL ng_late_ack got ms=%b hid=%h pairs=%0d exp 0 0000 8", ms, hidden, pairs_left); end
  endtask

  task automatic test_write_rules();
    int n, mfs;
    // Write and pick of card 0 in one cycle: compare still sees the old symbol 0.
    wr_en = 1'b1; wr_addr = 4'd0; wr_sym = 4'd9; cur_idx = 4'd0; s = 1'b1;
    step();
    wr_en = 1'b0; s = 1'b0;
    pick(4'd1);
    checks++; if (chk_req !== 1'b1 || mf !== 1'b0) begin errors++; $display("FAIL wr_pick_old got req=%b mf=%b exp 1 0", chk_req, mf); end
    pulse_new_game();
    pick(4'd0);
    pick(4'd1);
    checks++; if (mf !== 1'b1 || chk_req !== 1'b0) begin errors++; $display("FAIL wr_landed got mf=%b req=%b exp 1 0", mf, chk_req); end
    hold_len(16'h0003, n, mfs);
    checks++; if (sel !== 16'h0) begin errors++; $display("FAIL wr_hold_exit got sel=%h exp 0000", sel); end
    pick(4'd2);
    write_sym(4'd3, 4'd15);
    pick(4'd3);
    checks++; if (chk_req !== 1'b1 || mf !== 1'b0) begin errors++; $display("FAIL wr_dropped_in_one got req=%b mf=%b exp 1 0", chk_req, mf); end
    pulse_new_game();
  endtask

  initial begin
    test_reset();
    test_match();
    test_mismatch();
    test_deselect_and_ignore();
    test_checker_reject();
    test_full_game();
    test_new_game_in_check();
    test_write_rules();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
